// File: rtl/pifo_arbiter_pkg.sv
// Shared PIFO definitions: default rank/meta widths, packed entry width and insert FSM states.
package pifo_arbiter_pkg;

    localparam int PIFO_RANK_WIDTH = 10;
    localparam int PIFO_META_WIDTH = 20;

    typedef enum logic {
        INS_EMPTY = 1'b0,
        INS_HELD  = 1'b1
    } ins_state_e;

    // A packed entry is {rank, meta}, rank in the upper bits.
    function automatic int entry_width(input int rank_w, input int meta_w);
        return rank_w + meta_w;
    endfunction

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pifo_arbiter_if.sv
// Signal bundle between the ingress ports, the arbiter, pifo_top and the egress consumer.
interface pifo_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int RANK_WIDTH = 10,
    parameter int META_WIDTH = 20,
    parameter int CNT_WIDTH  = 16
);
    logic [NUM_PORTS-1:0]            in_valid;
    logic [NUM_PORTS-1:0]            in_ready;
    logic [NUM_PORTS*RANK_WIDTH-1:0] in_rank;
    logic [NUM_PORTS*META_WIDTH-1:0] in_meta;
    logic                            pifo_insert;
    logic [RANK_WIDTH-1:0]           pifo_rank_in;
    logic [META_WIDTH-1:0]           pifo_meta_in;
    logic                            pifo_busy;
    logic                            pifo_full;
    logic                            pifo_remove;
    logic                            pifo_valid_out;
    logic [RANK_WIDTH-1:0]           pifo_rank_out;
    logic [META_WIDTH-1:0]           pifo_meta_out;
    logic                            out_valid;
    logic                            out_ready;
    logic [RANK_WIDTH-1:0]           out_rank;
    logic [META_WIDTH-1:0]           out_meta;
    logic [CNT_WIDTH-1:0]            occupancy;

    modport master (
        input  in_valid, in_rank, in_meta, pifo_busy, pifo_full,
               pifo_valid_out, pifo_rank_out, pifo_meta_out, out_ready,
        output in_ready, pifo_insert, pifo_rank_in, pifo_meta_in, pifo_remove,
               out_valid, out_rank, out_meta, occupancy
    );

    modport slave (
        output in_valid, in_rank, in_meta, pifo_busy, pifo_full,
               pifo_valid_out, pifo_rank_out, pifo_meta_out, out_ready,
        input  in_ready, pifo_insert, pifo_rank_in, pifo_meta_in, pifo_remove,
               out_valid, out_rank, out_meta, occupancy
    );
endinterface

// File: rtl/pifo_arbiter_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, searching upward with wrap.
module rr_arbiter
    import pifo_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);

    logic found;

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                grant[(int'(ptr) + i) % N] = 1'b1;
                idx   = PW'((int'(ptr) + i) % N);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pifo_arbiter.sv
// Multi-port ingress arbiter in front of pifo_top, with a 2-entry egress FIFO and occupancy counter.
module pifo_arbiter
    import pifo_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int RANK_WIDTH = PIFO_RANK_WIDTH,
    parameter int META_WIDTH = PIFO_META_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_ready,
    input  logic [NUM_PORTS*RANK_WIDTH-1:0] in_rank,
    input  logic [NUM_PORTS*META_WIDTH-1:0] in_meta,
    output logic                            pifo_insert,
    output logic [RANK_WIDTH-1:0]           pifo_rank_in,
    output logic [META_WIDTH-1:0]           pifo_meta_in,
    input  logic                            pifo_busy,
    input  logic                            pifo_full,
    output logic                            pifo_remove,
    input  logic                            pifo_valid_out,
    input  logic [RANK_WIDTH-1:0]           pifo_rank_out,
    input  logic [META_WIDTH-1:0]           pifo_meta_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [RANK_WIDTH-1:0]           out_rank,
    output logic [META_WIDTH-1:0]           out_meta,
    output logic [CNT_WIDTH-1:0]            occupancy
);

    localparam int PW = ptr_width(NUM_PORTS);
    localparam int EW = entry_width(RANK_WIDTH, META_WIDTH);

    ins_state_e           state_q, state_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [EW-1:0]        hold_q, hold_d;
    logic [NUM_PORTS-1:0] grant;
    logic [PW-1:0]        grant_idx;
    logic                 issue;
    logic                 transfer;

    rr_arbiter #(.N(NUM_PORTS)) u_rr (
        .req   (in_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        issue    = ~rst & (state_q == INS_HELD) & ~pifo_busy & ~pifo_full;
        // The register can take a new entry when free or when it is emptying this cycle.
        in_ready = (~rst & ((state_q == INS_EMPTY) | issue)) ? grant : '0;
        transfer = |in_ready;
        if (transfer) begin
            state_d  = INS_HELD;
            hold_d   = {in_rank[grant_idx*RANK_WIDTH +: RANK_WIDTH],
                        in_meta[grant_idx*META_WIDTH +: META_WIDTH]};
            rr_ptr_d = (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end else if (issue) begin
            state_d = INS_EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INS_EMPTY;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // NOTE: data registers carry no reset; the state/count qualifiers say when they are meaningful.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign pifo_insert  = issue;
    assign pifo_rank_in = hold_q[EW-1 -: RANK_WIDTH];
    assign pifo_meta_in = hold_q[META_WIDTH-1:0];

    logic [EW-1:0] fifo_q [2];
    logic          rd_ptr_q, wr_ptr_q;
    logic [1:0]    fifo_cnt_q;
    logic [1:0]    fifo_commit;
    logic          remove_pending_q;
    logic          fifo_pop;

    // Count an in-flight removal so the FIFO can never be over-committed.
    assign fifo_commit = fifo_cnt_q + {1'b0, remove_pending_q};
    assign pifo_remove = ~rst & pifo_valid_out & (fifo_commit < 2'd2);
    assign out_valid   = ~rst & (fifo_cnt_q != 2'd0);
    assign fifo_pop    = out_valid & out_ready;
    assign out_rank    = fifo_q[rd_ptr_q][EW-1 -: RANK_WIDTH];
    assign out_meta    = fifo_q[rd_ptr_q][META_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (pifo_remove) begin
            fifo_q[wr_ptr_q] <= {pifo_rank_out, pifo_meta_out};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q         <= 1'b0;
            wr_ptr_q         <= 1'b0;
            fifo_cnt_q       <= 2'd0;
            remove_pending_q <= 1'b0;
        end else begin
            remove_pending_q <= pifo_remove;
            if (pifo_remove) wr_ptr_q <= ~wr_ptr_q;
            if (fifo_pop)    rd_ptr_q <= ~rd_ptr_q;
            case ({pifo_remove, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    logic [CNT_WIDTH-1:0] occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else if (pifo_insert && !pifo_remove && occ_q != '1) begin
            occ_q <= occ_q + 1'b1;
        end else if (pifo_remove && !pifo_insert && occ_q != '0) begin
            occ_q <= occ_q - 1'b1;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_pifo_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference model of pifo_arbiter.
module tb_pifo_arbiter;
    import pifo_arbiter_pkg::*;

    localparam int NP = 4;
    localparam int RW = 10;
    localparam int MW = 20;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pifo_arbiter_if #(.NUM_PORTS(NP), .RANK_WIDTH(RW), .META_WIDTH(MW), .CNT_WIDTH(CW)) bus ();

    pifo_arbiter #(.NUM_PORTS(NP), .RANK_WIDTH(RW), .META_WIDTH(MW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (bus.in_valid),
        .in_ready       (bus.in_ready),
        .in_rank        (bus.in_rank),
        .in_meta        (bus.in_meta),
        .pifo_insert    (bus.pifo_insert),
        .pifo_rank_in   (bus.pifo_rank_in),
        .pifo_meta_in   (bus.pifo_meta_in),
        .pifo_busy      (bus.pifo_busy),
        .pifo_full      (bus.pifo_full),
        .pifo_remove    (bus.pifo_remove),
        .pifo_valid_out (bus.pifo_valid_out),
        .pifo_rank_out  (bus.pifo_rank_out),
        .pifo_meta_out  (bus.pifo_meta_out),
        .out_valid      (bus.out_valid),
        .out_ready      (bus.out_ready),
        .out_rank       (bus.out_rank),
        .out_meta       (bus.out_meta),
        .occupancy      (bus.occupancy)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic idle_inputs();
        bus.in_valid       = '0;
        bus.in_rank        = '0;
        bus.in_meta        = '0;
        bus.pifo_busy      = 1'b0;
        bus.pifo_full      = 1'b0;
        bus.pifo_valid_out = 1'b0;
        bus.pifo_rank_out  = '0;
        bus.pifo_meta_out  = '0;
        bus.out_ready      = 1'b0;
    endtask

    task automatic set_port(input int p, input logic [RW-1:0] r, input logic [MW-1:0] m);
        bus.in_rank[p*RW +: RW] = r;
        bus.in_meta[p*MW +: MW] = m;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        bus.in_valid = '1;
        bus.pifo_valid_out = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== '0) begin n_mis++; $display("FAIL reset_in_ready: got %0h want 0", bus.in_ready); end
        n_cmp++;
        if ({bus.pifo_insert, bus.pifo_remove, bus.out_valid} !== 3'b000) begin
            n_mis++; $display("FAIL reset_strobes: got %0b want 000", {bus.pifo_insert, bus.pifo_remove, bus.out_valid});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.occupancy !== '0) begin n_mis++; $display("FAIL reset_occupancy: got %0d want 0", bus.occupancy); end
        n_cmp++;
        if ({bus.pifo_insert, bus.out_valid} !== 2'b00) begin
            n_mis++; $display("FAIL reset_after: got %0b want 00", {bus.pifo_insert, bus.out_valid});
        end
    endtask

    task automatic test_rr_all();
        logic [NP-1:0] exp_g;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = '1;
            for (int p = 0; p < NP; p++) set_port(p, RW'(100 + p), MW'(200 + p));
            #1;
            exp_g = NP'(1 << (c % NP));
            n_cmp++;
            if (bus.in_ready !== exp_g) begin n_mis++; $display("FAIL rr_grant[%0d]: got %b want %b", c, bus.in_ready, exp_g); end
            n_cmp++;
            if (bus.pifo_insert !== (c >= 1)) begin n_mis++; $display("FAIL rr_insert[%0d]: got %b want %b", c, bus.pifo_insert, c >= 1); end
            if (c >= 1) begin
                n_cmp++;
                if ({bus.pifo_rank_in, bus.pifo_meta_in} !== {RW'(100 + (c - 1) % NP), MW'(200 + (c - 1) % NP)}) begin
                    n_mis++; $display("FAIL rr_data[%0d]: got %0d want %0d", c, bus.pifo_rank_in, 100 + (c - 1) % NP);
                end
            end
        end
        @(negedge clk);
        bus.in_valid = '0;
        #1;
        n_cmp++;
        if ({bus.pifo_insert, bus.pifo_rank_in} !== {1'b1, RW'(100)}) begin
            n_mis++; $display("FAIL rr_last_insert: got %b/%0d want 1/100", bus.pifo_insert, bus.pifo_rank_in);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.pifo_insert !== 1'b0) begin n_mis++; $display("FAIL rr_idle: got %b want 0", bus.pifo_insert); end
    endtask

    task automatic test_wrap();
        logic [NP-1:0] valid_pat [3];
        logic [NP-1:0] exp_g [3];
        valid_pat[0] = 4'b0100; exp_g[0] = 4'b0100;
        valid_pat[1] = 4'b0100; exp_g[1] = 4'b0100;
        valid_pat[2] = 4'b1101; exp_g[2] = 4'b1000;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            bus.in_valid = valid_pat[s];
            for (int p = 0; p < NP; p++) set_port(p, RW'(40 + 4 * s + p), MW'(400 + s));
            #1;
            n_cmp++;
            if (bus.in_ready !== exp_g[s]) begin n_mis++; $display("FAIL wrap_grant[%0d]: got %b want %b", s, bus.in_ready, exp_g[s]); end
            @(negedge clk);
            bus.in_valid = '0;
            #1;
            n_cmp++;
            if ({bus.pifo_insert, bus.pifo_rank_in} !== {1'b1, RW'(40 + 4 * s + (s == 2 ? 3 : 2))}) begin
                n_mis++; $display("FAIL wrap_insert[%0d]: got %b/%0d", s, bus.pifo_insert, bus.pifo_rank_in);
            end
        end
    endtask

    task automatic test_busy_hold();
        int ins_cnt = 0;
        @(negedge clk);
        bus.in_valid = 4'b0010;
        set_port(1, RW'('h155), MW'('hABCDE));
        #1;
        n_cmp++;
        if (bus.in_ready !== 4'b0010) begin n_mis++; $display("FAIL hold_grant: got %b want 0010", bus.in_ready); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.pifo_busy = (k < 5);
            bus.pifo_full = (k == 5);
            bus.in_valid  = '1;
            for (int p = 0; p < NP; p++) set_port(p, RW'($urandom), MW'($urandom));
            #1;
            n_cmp++;
            if ({bus.pifo_insert, bus.in_ready} !== '0) begin
                n_mis++; $display("FAIL hold_stall[%0d]: insert %b ready %b want 0/0", k, bus.pifo_insert, bus.in_ready);
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.pifo_busy = 1'b0;
            bus.pifo_full = 1'b0;
            bus.in_valid  = '0;
            #1;
            if (bus.pifo_insert) begin
                ins_cnt++;
                n_cmp++;
                if ({bus.pifo_rank_in, bus.pifo_meta_in} !== {RW'('h155), MW'('hABCDE)}) begin
                    n_mis++; $display("FAIL hold_data: got %0h/%0h want 155/abcde", bus.pifo_rank_in, bus.pifo_meta_in);
                end
            end
        end
        n_cmp++;
        if (ins_cnt !== 1) begin n_mis++; $display("FAIL hold_insert_count: got %0d want 1", ins_cnt); end
    endtask

    task automatic test_egress();
        int rm_cnt = 0;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.pifo_valid_out = 1'b1;
            bus.pifo_rank_out  = (c == 0) ? RW'(7) : RW'(9);
            bus.pifo_meta_out  = (c == 0) ? MW'(77) : MW'(99);
            bus.out_ready      = 1'b0;
            #1;
            if (bus.pifo_remove) rm_cnt++;
            if (c >= 1) begin
                n_cmp++;
                if ({bus.out_valid, bus.out_rank} !== {1'b1, RW'(7)}) begin
                    n_mis++; $display("FAIL egress_head[%0d]: valid %b rank %0d want 1/7", c, bus.out_valid, bus.out_rank);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (bus.pifo_remove !== 1'b0) begin n_mis++; $display("FAIL egress_stop: got %b want 0", bus.pifo_remove); end
            end
        end
        n_cmp++;
        if (rm_cnt !== 2) begin n_mis++; $display("FAIL egress_removals: got %0d want 2", rm_cnt); end
        for (int d = 0; d < 3; d++) begin
            @(negedge clk);
            bus.pifo_valid_out = 1'b0;
            bus.out_ready      = 1'b1;
            #1;
            n_cmp++;
            if (d < 2 && {bus.out_valid, bus.out_rank, bus.out_meta} !==
                    {1'b1, (d == 0) ? RW'(7) : RW'(9), (d == 0) ? MW'(77) : MW'(99)}) begin
                n_mis++; $display("FAIL egress_drain[%0d]: valid %b rank %0d", d, bus.out_valid, bus.out_rank);
            end else if (d == 2 && bus.out_valid !== 1'b0) begin
                n_mis++; $display("FAIL egress_empty: got %b want 0", bus.out_valid);
            end
        end
        n_cmp++;
        if (bus.occupancy !== '0) begin n_mis++; $display("FAIL occ_floor: got %0d want 0", bus.occupancy); end
    endtask

    task automatic test_occupancy();
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.in_valid = 4'b0001;
            set_port(0, RW'(c), MW'(c));
            #1;
        end
        @(negedge clk);
        bus.in_valid       = '0;
        bus.pifo_valid_out = 1'b1;
        #1;
        n_cmp++;
        if ({bus.occupancy, bus.pifo_insert, bus.pifo_remove} !== {CW'(3), 2'b11}) begin
            n_mis++; $display("FAIL occ_both: occ %0d ins %b rm %b want 3/1/1", bus.occupancy, bus.pifo_insert, bus.pifo_remove);
        end
        @(negedge clk);
        bus.pifo_valid_out = 1'b0;
        #1;
        n_cmp++;
        if (bus.occupancy !== CW'(3)) begin n_mis++; $display("FAIL occ_hold3: got %0d want 3", bus.occupancy); end
        @(negedge clk);
        bus.pifo_valid_out = 1'b1;
        #1;
        n_cmp++;
        if ({bus.pifo_insert, bus.pifo_remove} !== 2'b01) begin
            n_mis++; $display("FAIL occ_remove_only: got %b want 01", {bus.pifo_insert, bus.pifo_remove});
        end
        @(negedge clk);
        bus.pifo_valid_out = 1'b1;
        bus.in_valid       = 4'b0001;
        rst                = 1'b1;
        #1;
        n_cmp++;
        if ({bus.occupancy, bus.in_ready} !== {CW'(2), 4'b0000}) begin
            n_mis++; $display("FAIL occ_pre_reset: occ %0d ready %b want 2/0000", bus.occupancy, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        n_cmp++;
        if ({bus.occupancy, bus.out_valid} !== {CW'(0), 1'b0}) begin
            n_mis++; $display("FAIL occ_mid_reset: occ %0d valid %b want 0/0", bus.occupancy, bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [RW+MW-1:0] ins_q [$];
        logic [RW+MW-1:0] out_q [$];
        logic [NP-1:0]    exp_g;
        int  rr = 0, occ = 0, gidx;
        bit  pend = 0, exp_ins, exp_rm, exp_ov, free;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            bus.in_valid = NP'($urandom);
            for (int p = 0; p < NP; p++) set_port(p, RW'($urandom), MW'($urandom));
            bus.pifo_busy      = ($urandom_range(0, 3) == 0);
            bus.pifo_full      = ($urandom_range(0, 7) == 0);
            bus.pifo_valid_out = $urandom_range(0, 1) == 1;
            bus.pifo_rank_out  = RW'($urandom);
            bus.pifo_meta_out  = MW'($urandom);
            bus.out_ready      = ($urandom_range(0, 2) != 0);
            #1;
            exp_ins = (ins_q.size() != 0) && !bus.pifo_busy && !bus.pifo_full;
            free    = (ins_q.size() == 0) || exp_ins;
            exp_g   = '0;
            gidx    = -1;
            if (free) begin
                for (int i = 0; i < NP; i++) begin
                    if (gidx < 0 && bus.in_valid[(rr + i) % NP]) gidx = (rr + i) % NP;
                end
            end
            if (gidx >= 0) exp_g[gidx] = 1'b1;
            exp_rm = bus.pifo_valid_out && (out_q.size() + int'(pend) < 2);
            exp_ov = (out_q.size() != 0);

            n_cmp++;
            if ({bus.in_ready, bus.pifo_insert, bus.pifo_remove, bus.out_valid} !== {exp_g, exp_ins, exp_rm, exp_ov}) begin
                n_mis++;
                if (n_mis < 40) $display("FAIL rand_ctrl@%0d: got %b want %b", cyc,
                    {bus.in_ready, bus.pifo_insert, bus.pifo_remove, bus.out_valid}, {exp_g, exp_ins, exp_rm, exp_ov});
            end
            if (exp_ins) begin
                n_cmp++;
                if ({bus.pifo_rank_in, bus.pifo_meta_in} !== ins_q[0]) begin
                    n_mis++;
                    if (n_mis < 40) $display("FAIL rand_insert@%0d: got %0h want %0h", cyc, {bus.pifo_rank_in, bus.pifo_meta_in}, ins_q[0]);
                end
            end
            if (exp_ov) begin
                n_cmp++;
                if ({bus.out_rank, bus.out_meta} !== out_q[0]) begin
                    n_mis++;
                    if (n_mis < 40) $display("FAIL rand_out@%0d: got %0h want %0h", cyc, {bus.out_rank, bus.out_meta}, out_q[0]);
                end
            end
            n_cmp++;
            if (bus.occupancy !== CW'(occ)) begin
                n_mis++;
                if (n_mis < 40) $display("FAIL rand_occ@%0d: got %0d want %0d", cyc, bus.occupancy, occ);
            end

            if (exp_ins) void'(ins_q.pop_front());
            if (gidx >= 0) begin
                ins_q.push_back({bus.in_rank[gidx*RW +: RW], bus.in_meta[gidx*MW +: MW]});
                rr = (gidx + 1) % NP;
            end
            if (exp_ov && bus.out_ready) void'(out_q.pop_front());
            if (exp_rm) out_q.push_back({bus.pifo_rank_out, bus.pifo_meta_out});
            pend = exp_rm;
            if (exp_ins && !exp_rm) occ++;
            else if (exp_rm && !exp_ins && occ > 0) occ--;
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_rr_all();
        test_wrap();
        test_busy_hold();
        test_egress();
        test_occupancy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
